fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch sequencer that sits directly upstream of the instruction register. It owns the program counter and issues one read per fetch request on the memory interface. On the cycle the memory returns data it asserts the instruction register's load enable, so the word on the memory read-data bus (wired straight to the register's data input) is captured at that edge. It also accepts branch redirects and a halt input from the control unit.

Parameters:
- ADDR_BUS_WIDTH, 8, width of PC and memory address.
- RESET_VECTOR, 0, PC value after reset.
- PC_INCREMENT, 1, PC advance per completed fetch.
- TIMEOUT_CYCLES, 16, wait-cycle limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  control requests the next instruction; level-sampled in IDLE.
- branch_valid  in  1  redirect the PC; sampled in IDLE only.
- branch_target  in  ADDR_BUS_WIDTH  redirect address.
- halt  in  1  blocks new fetches.
- mem_ready  in  1  memory read data is valid this cycle.
- mem_rd  out  1  read strobe.
- mem_addr  out  ADDR_BUS_WIDTH  read address; always equals pc.
- ir_en  out  1  load enable for the instruction register.
- pc  out  ADDR_BUS_WIDTH  current PC.
- fetch_done  out  1  one-cycle pulse, registered, the cycle after a load.
- fetch_err  out  1  timeout pulse; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_VECTOR, state=IDLE, mem_rd=0, fetch_done=0, fetch_err=0, wait counter=0. rst overrides all other inputs and aborts an in-flight read without asserting ir_en.
- FSM states: IDLE, REQ.
- IDLE:
  - mem_rd=0, ir_en=0.
  - branch_valid=1: pc<=branch_target and go to REQ. Branch has priority, and the fetch proceeds from the target even if fetch_req=0 that cycle.
  - Otherwise, fetch_req=1 and halt=0: go to REQ, pc unchanged.
  - branch_valid=1 with halt=1: pc is loaded, but the block stays in IDLE.
- REQ:
  - mem_rd=1, mem_addr=pc.
  - ir_en = (state==REQ) && mem_ready. This is combinational, so the instruction register captures the data in the same cycle.
  - On mem_ready=1: pc<=pc+PC_INCREMENT (wraps modulo 2^ADDR_BUS_WIDTH), fetch_done<=1 on the next cycle, return to IDLE.
  - branch_valid is ignored in REQ. halt asserted during REQ does not cancel the in-flight read.
- Minimum latency: request in IDLE at cycle N, mem_rd at N+1, with zero-wait memory ir_en at N+1, fetch_done at N+2. Back-to-back fetches issue every 2 cycles.
- fetch_done and fetch_err are never high in the same cycle.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro:
  - A wait counter clears on entry to REQ and increments each REQ cycle while mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with mem_ready still 0: return to IDLE, drop mem_rd, leave pc unchanged, no ir_en, fetch_err=1 for one cycle.
  - mem_ready=1 on that same cycle wins: a normal completion, no error.
- Without the macro: no counter, REQ waits indefinitely, fetch_err constant 0.

Decomposition:
- Shared param.v include holds DATA_BUS_WIDTH, INSTRUCTION_WIDTH, ADDR_BUS_WIDTH, RESET_VECTOR, and the state encodings FETCH_IDLE=1'b0 and FETCH_REQ=1'b1.
- One natural sub-module: pc_counter. It handles load of branch_target, increment by PC_INCREMENT, and reset to RESET_VECTOR, with priority reset > load > increment.

Test Plan:
- Reset then fetch_req=1 held, mem_ready=1 always -> mem_addr sequence 0,1,2,3; ir_en high on every REQ cycle; fetch_done pulses every 2 cycles; pc=4 after 4 fetches.
- mem_ready delayed 3 cycles -> mem_rd high 4 cycles, ir_en one cycle coincident with mem_ready, pc increments exactly once.
- IDLE with branch_valid=1, branch_target=0x40 -> next cycle mem_rd=1, mem_addr=0x40; after completion pc=0x41. branch_valid pulsed mid-REQ -> no effect.
- pc=0xFF, complete a fetch -> pc wraps to 0x00. halt=1 during REQ -> read completes, then stays IDLE despite fetch_req=1.
- rst asserted mid-REQ -> next cycle pc=RESET_VECTOR, mem_rd=0, no ir_en, no fetch_done.
- FETCH_TIMEOUT_EN with mem_ready stuck at 0 -> fetch_err pulses after 16 REQ cycles, pc unchanged. Without the macro -> mem_rd stays high indefinitely.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_unit_pkg;

  localparam int DATA_BUS_WIDTH    = 16;
  localparam int INSTRUCTION_WIDTH = 16;
  localparam int ADDR_BUS_WIDTH    = 8;
  localparam logic [ADDR_BUS_WIDTH-1:0] RESET_VECTOR = '0;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: reset > branch load > increment, wrapping modulo 2^ADDR_BUS_WIDTH.
module fetch_unit_pc_counter #(
  parameter int                        ADDR_BUS_WIDTH = 8,
  parameter logic [ADDR_BUS_WIDTH-1:0] RESET_VECTOR   = '0,
  parameter logic [ADDR_BUS_WIDTH-1:0] PC_INCREMENT   = ADDR_BUS_WIDTH'(1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [ADDR_BUS_WIDTH-1:0] load_val,
  input  logic                      inc,
  output logic [ADDR_BUS_WIDTH-1:0] pc
);

  logic [ADDR_BUS_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_INCREMENT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, issues one memory read per fetch and loads the IR.
// Optional read timeout enabled by defining FETCH_TIMEOUT_EN.
//
// state      | meaning
// FETCH_IDLE | no read outstanding; accepts branch redirects and fetch requests
// FETCH_REQ  | mem_rd asserted at pc, waiting for mem_ready
module fetch_unit #(
  parameter int                        ADDR_BUS_WIDTH = fetch_unit_pkg::ADDR_BUS_WIDTH,
  parameter logic [ADDR_BUS_WIDTH-1:0] RESET_VECTOR   = ADDR_BUS_WIDTH'(fetch_unit_pkg::RESET_VECTOR),
  parameter logic [ADDR_BUS_WIDTH-1:0] PC_INCREMENT   = ADDR_BUS_WIDTH'(1),
  parameter int                        TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_req,
  input  logic                      branch_valid,
  input  logic [ADDR_BUS_WIDTH-1:0] branch_target,
  input  logic                      halt,
  input  logic                      mem_ready,
  output logic                      mem_rd,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic                      ir_en,
  output logic [ADDR_BUS_WIDTH-1:0] pc,
  output logic                      fetch_done,
  output logic                      fetch_err
);

  import fetch_unit_pkg::*;

  fetch_state_e state_q, state_d;
  logic         fetch_done_q, fetch_done_d;
  logic         fetch_err_q, fetch_err_d;
  logic         timeout;
  logic         pc_load;
  logic         pc_inc;

`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Held at zero in IDLE so every REQ entry starts counting from zero.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == FETCH_IDLE) begin
      wait_cnt_d = '0;
    end else if (!mem_ready) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout = (state_q == FETCH_REQ) && !mem_ready &&
                   (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_IDLE: if ((branch_valid || fetch_req) && !halt) state_d = FETCH_REQ;
      FETCH_REQ:  if (mem_ready || timeout) state_d = FETCH_IDLE;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  // ir_en is gated by rst so a reset landing on a ready cycle never loads the IR.
  always_comb begin
    mem_rd  = (state_q == FETCH_REQ);
    ir_en   = (state_q == FETCH_REQ) && mem_ready && !rst;
    pc_load = (state_q == FETCH_IDLE) && branch_valid;
    pc_inc  = ir_en;
  end

  assign fetch_done_d = ir_en;
  assign fetch_err_d  = timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_done_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      fetch_done_q <= fetch_done_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  fetch_unit_pc_counter #(
    .ADDR_BUS_WIDTH (ADDR_BUS_WIDTH),
    .RESET_VECTOR   (RESET_VECTOR),
    .PC_INCREMENT   (PC_INCREMENT)
  ) u_pc_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (branch_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign mem_addr   = pc;
  assign fetch_done = fetch_done_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a monitor pops the expected fetch address on every IR load.
module tb_fetch_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          halt;
  logic          mem_ready;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          ir_en;
  logic [AW-1:0] pc;
  logic          fetch_done;
  logic          fetch_err;

  int            n_vec    = 0;
  int            n_err    = 0;
  int            done_cnt = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_req     (fetch_req),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halt          (halt),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .ir_en         (ir_en),
    .pc            (pc),
    .fetch_done    (fetch_done),
    .fetch_err     (fetch_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: every IR load must match the next queued address.
  always @(negedge clk) begin
    if (fetch_done === 1'b1) done_cnt++;
    if (fetch_done === 1'b1 && fetch_err === 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL done_err_overlap: both high at %0t", $time);
    end
    if (ir_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ir_en: addr %0h, expected no load at %0t", mem_addr, $time);
      end else begin
        exp_addr = exp_q.pop_front();
        chk("ir_load_addr", 32'(mem_addr), 32'(exp_addr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fetch_req = 1'b0; branch_valid = 1'b0; halt = 1'b0;
    mem_ready = 1'b0; branch_target = '0;
    nxt(); nxt();
    smp();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_done", 32'(fetch_done), 0);
    chk("rst_err", 32'(fetch_err), 0);
    nxt();
    rst = 1'b0;

    // Back-to-back zero-wait fetches.
    fetch_req = 1'b1; mem_ready = 1'b1;
    for (int a = 0; a < 4; a++) exp_q.push_back(AW'(a));
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("seq_mem_rd", 32'(mem_rd), 32'(i % 2 == 1));
      chk("seq_done", 32'(fetch_done), 32'(i % 2 == 0 && i > 0));
      if (i % 2 == 1) chk("seq_addr", 32'(mem_addr), 32'(i / 2));
      nxt();
    end
    fetch_req = 1'b0;
    smp();
    chk("seq_pc", 32'(pc), 4);
    chk("seq_done_last", 32'(fetch_done), 1);

    // Three wait states.
    nxt();
    fetch_req = 1'b1; mem_ready = 1'b0;
    exp_q.push_back(8'h04);
    nxt();
    fetch_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      smp();
      chk("wait_mem_rd", 32'(mem_rd), 1);
      chk("wait_ir_en", 32'(ir_en), 32'(k == 3));
      chk("wait_pc", 32'(pc), 4);
      nxt();
    end
    mem_ready = 1'b0;
    smp();
    chk("wait_rd_off", 32'(mem_rd), 0);
    chk("wait_pc_inc", 32'(pc), 5);
    chk("wait_done", 32'(fetch_done), 1);
    nxt();
    smp();
    chk("wait_done_pulse", 32'(fetch_done), 0);

    // Branch from IDLE without fetch_req; branch during REQ ignored.
    nxt();
    branch_valid = 1'b1; branch_target = 8'h40;
    nxt();
    branch_target = 8'h77;
    smp();
    chk("br_mem_rd", 32'(mem_rd), 1);
    chk("br_addr", 32'(mem_addr), 32'h40);
    nxt();
    smp();
    chk("br_ignored_addr", 32'(mem_addr), 32'h40);
    chk("br_ignored_rd", 32'(mem_rd), 1);
    nxt();
    branch_valid = 1'b0; mem_ready = 1'b1;
    exp_q.push_back(8'h40);
    nxt();
    mem_ready = 1'b0;
    smp();
    chk("br_pc", 32'(pc), 32'h41);
    chk("br_idle", 32'(mem_rd), 0);

    // PC wrap at 0xFF.
    nxt();
    branch_valid = 1'b1; branch_target = 8'hFF; mem_ready = 1'b1;
    exp_q.push_back(8'hFF);
    nxt();
    branch_valid = 1'b0;
    smp();
    chk("wrap_addr", 32'(mem_addr), 32'hFF);
    nxt();
    mem_ready = 1'b0;
    smp();
    chk("wrap_pc", 32'(pc), 0);

    // Halt during REQ lets the read finish, then blocks new fetches.
    nxt();
    fetch_req = 1'b1;
    nxt();
    halt = 1'b1;
    smp();
    chk("halt_rd", 32'(mem_rd), 1);
    nxt();
    mem_ready = 1'b1;
    exp_q.push_back(8'h00);
    nxt();
    mem_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      smp();
      chk("halt_idle_rd", 32'(mem_rd), 0);
      chk("halt_pc", 32'(pc), 1);
      nxt();
    end
    branch_valid = 1'b1; branch_target = 8'h20;
    nxt();
    branch_valid = 1'b0; halt = 1'b0; fetch_req = 1'b0;
    smp();
    chk("halt_br_pc", 32'(pc), 32'h20);
    chk("halt_br_rd", 32'(mem_rd), 0);

    // Reset mid-REQ on a ready cycle.
    nxt();
    fetch_req = 1'b1;
    nxt();
    fetch_req = 1'b0;
    smp();
    chk("rstm_rd", 32'(mem_rd), 1);
    nxt();
    mem_ready = 1'b1; rst = 1'b1;
    smp();
    chk("rstm_ir_en", 32'(ir_en), 0);
    nxt();
    rst = 1'b0; mem_ready = 1'b0;
    smp();
    chk("rstm_pc", 32'(pc), 0);
    chk("rstm_rd_off", 32'(mem_rd), 0);
    chk("rstm_done", 32'(fetch_done), 0);
    nxt();
    smp();
    chk("rstm_done2", 32'(fetch_done), 0);
    chk("rstm_pc2", 32'(pc), 0);

    // Memory never answers.
    nxt();
    fetch_req = 1'b1;
    nxt();
    fetch_req = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      smp();
      chk("to_rd", 32'(mem_rd), 1);
      chk("to_err", 32'(fetch_err), 0);
      nxt();
    end
    smp();
    chk("to_rd_off", 32'(mem_rd), 0);
    chk("to_err_pulse", 32'(fetch_err), 1);
    chk("to_pc", 32'(pc), 0);
    nxt();
    smp();
    chk("to_err_clear", 32'(fetch_err), 0);
`else
    for (int k = 0; k < 40; k++) begin
      smp();
      chk("stuck_rd", 32'(mem_rd), 1);
      chk("stuck_err", 32'(fetch_err), 0);
      nxt();
    end
`endif

    smp();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("done_pulses", 32'(done_cnt), 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
